// File: rtl/cp0_exception_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exception_unit_if
// Description : Commit-stage CP0 access / exception bundle between the core
//               pipeline (master) and the CP0 exception unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface cp0_exception_unit_if #(
    parameter int NUM_HW_INT = 5
);
    logic                  InstValid;
    logic [31:0]           InstPC;
    logic                  InDelaySlot;
    logic                  ExcSyscall;
    logic                  ExcEret;
    logic                  CP0RE;
    logic [4:0]            CP0RAddr;
    logic                  CP0WE;
    logic [4:0]            CP0WAddr;
    logic [31:0]           CP0WData;
    logic [NUM_HW_INT-1:0] HwInt;
    logic [31:0]           CP0RData;
    logic                  Flush;
    logic                  PcLoad;
    logic [31:0]           PcTarget;
    logic                  TimerIrq;

    modport master (
        output InstValid, InstPC, InDelaySlot, ExcSyscall, ExcEret,
               CP0RE, CP0RAddr, CP0WE, CP0WAddr, CP0WData, HwInt,
        input  CP0RData, Flush, PcLoad, PcTarget, TimerIrq
    );

    modport slave (
        input  InstValid, InstPC, InDelaySlot, ExcSyscall, ExcEret,
               CP0RE, CP0RAddr, CP0WE, CP0WAddr, CP0WData, HwInt,
        output CP0RData, Flush, PcLoad, PcTarget, TimerIrq
    );
endinterface
`default_nettype wire

// File: rtl/cp0_exception_unit.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exception_unit
// Description : MIPS32 CP0 register file (Count, Compare, Status, Cause, EPC)
//               with synchronised HW interrupts, Count/Compare timer and a
//               two-state exception sequencer (flush, then PC redirect).
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_exception_unit #(
    parameter int          NUM_HW_INT = 5,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_8000,
    parameter int          COUNT_DIV  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cp0_exception_unit_if.slave   bus
);

    localparam int              c_PS_W     = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [c_PS_W-1:0] c_PS_MAX = c_PS_W'(COUNT_DIV - 1);
    localparam logic [4:0]      c_REG_COUNT   = 5'd9;
    localparam logic [4:0]      c_REG_COMPARE = 5'd11;
    localparam logic [4:0]      c_REG_STATUS  = 5'd12;
    localparam logic [4:0]      c_REG_CAUSE   = 5'd13;
    localparam logic [4:0]      c_REG_EPC     = 5'd14;
    localparam logic [4:0]      c_EXC_INT     = 5'd0;
    localparam logic [4:0]      c_EXC_SYS     = 5'd8;

    typedef enum logic [0:0] {
        ST_NORMAL   = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [NUM_HW_INT-1:0]   r_sync1;
    logic [NUM_HW_INT-1:0]   r_sync2;
    logic [31:0]             r_count;
    logic [c_PS_W-1:0]       r_prescale;
    logic [31:0]             r_compare;
    logic                    r_ie;
    logic                    r_exl;
    logic [7:0]              r_im;
    logic                    r_bd;
    logic                    r_ti;
    logic [1:0]              r_ip_sw;
    logic [4:0]              r_exc_code;
    logic [31:0]             r_epc;
    logic [31:0]             r_target;

    logic [4:0]              w_ip_hw;
    logic [7:0]              w_ip;
    logic                    w_int_pending;
    logic                    w_active;
    logic                    w_take_int;
    logic                    w_take_sys;
    logic                    w_take_eret;
    logic                    w_take_exc;
    logic                    w_flush;
    logic                    w_wr_en;
    logic                    w_wr_count;
    logic                    w_wr_compare;
    logic                    w_tick;
    logic [31:0]             w_count_inc;
    logic [31:0]             w_status;
    logic [31:0]             w_cause;
    logic [31:0]             w_rdata;

    // Map synchronised HW lines onto IP2..IP6; lines beyond NUM_HW_INT read 0.
    generate
        for (genvar i = 0; i < 5; i++) begin : g_ip_hw
            if (i < NUM_HW_INT) begin : g_used
                assign w_ip_hw[i] = r_sync2[i];
            end else begin : g_unused
                assign w_ip_hw[i] = 1'b0;
            end
        end
    endgenerate

    assign w_ip          = {r_ti, w_ip_hw, r_ip_sw};
    assign w_int_pending = (|(w_ip & r_im)) & r_ie & ~r_exl;
    assign w_status      = {16'h0, r_im, 6'h0, r_exl, r_ie};
    assign w_cause       = {r_bd, r_ti, 14'h0, w_ip, 1'b0, r_exc_code, 2'b00};
    assign w_count_inc   = r_count + 32'd1;

    // MTC0 commits only for a valid instruction in NORMAL that is not flushed.
    assign w_wr_en       = bus.InstValid & bus.CP0WE & (r_state == ST_NORMAL) & ~w_flush;
    assign w_wr_count    = w_wr_en & (bus.CP0WAddr == c_REG_COUNT);
    assign w_wr_compare  = w_wr_en & (bus.CP0WAddr == c_REG_COMPARE);
    assign w_tick        = ~w_wr_count & (r_prescale == c_PS_MAX);
    assign w_take_exc    = w_take_int | w_take_sys;

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_NORMAL;
        else        r_state <= w_state_nxt;
    end

    // Event arbitration (interrupt > syscall > eret) and next state.
    always_comb begin
        w_state_nxt = r_state;
        w_active    = 1'b0;
        w_take_int  = 1'b0;
        w_take_sys  = 1'b0;
        w_take_eret = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            ST_NORMAL: begin
                w_active = bus.InstValid;
                if (w_active && w_int_pending)   w_take_int  = 1'b1;
                else if (w_active && bus.ExcSyscall) w_take_sys  = 1'b1;
                else if (w_active && bus.ExcEret)    w_take_eret = 1'b1;
                w_flush = w_take_int | w_take_sys | w_take_eret;
                if (w_flush) w_state_nxt = ST_REDIRECT;
            end
            ST_REDIRECT: w_state_nxt = ST_NORMAL;
            default:     w_state_nxt = ST_NORMAL;
        endcase
    end

    assign bus.Flush    = w_flush;
    assign bus.PcLoad   = (r_state == ST_REDIRECT);
    assign bus.PcTarget = (r_state == ST_REDIRECT) ? r_target : 32'h0;
    assign bus.TimerIrq = r_ti;

    // Two-flop synchroniser for the asynchronous interrupt requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.HwInt;
            r_sync2 <= r_sync1;
        end
    end

    // Count with prescaler; an MTC0 to Count reloads it and restarts the prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= 32'h0;
            r_prescale <= '0;
        end else if (w_wr_count) begin
            r_count    <= bus.CP0WData;
            r_prescale <= '0;
        end else if (r_prescale == c_PS_MAX) begin
            r_count    <= w_count_inc;
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + c_PS_W'(1);
        end
    end

    // Compare register and timer flag; a Compare write beats a same-edge match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_compare <= 32'h0;
            r_ti      <= 1'b0;
        end else if (w_wr_compare) begin
            r_compare <= bus.CP0WData;
            r_ti      <= 1'b0;
        end else if (w_tick && (w_count_inc == r_compare)) begin
            r_ti      <= 1'b1;
        end
    end

    // Status: exception entry sets EXL, ERET clears it, otherwise MTC0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ie  <= 1'b0;
            r_exl <= 1'b0;
            r_im  <= 8'h0;
        end else if (w_take_exc) begin
            r_exl <= 1'b1;
        end else if (w_take_eret) begin
            r_exl <= 1'b0;
        end else if (w_wr_en && (bus.CP0WAddr == c_REG_STATUS)) begin
            r_ie  <= bus.CP0WData[0];
            r_exl <= bus.CP0WData[1];
            r_im  <= bus.CP0WData[15:8];
        end
    end

    // Cause/EPC: exception entry records the cause and restart address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bd       <= 1'b0;
            r_exc_code <= 5'h0;
            r_ip_sw    <= 2'b00;
            r_epc      <= 32'h0;
        end else if (w_take_exc) begin
            r_bd       <= bus.InDelaySlot;
            r_exc_code <= w_take_int ? c_EXC_INT : c_EXC_SYS;
            r_epc      <= bus.InDelaySlot ? (bus.InstPC - 32'd4) : bus.InstPC;
        end else if (w_wr_en) begin
            if (bus.CP0WAddr == c_REG_CAUSE) r_ip_sw <= bus.CP0WData[9:8];
            if (bus.CP0WAddr == c_REG_EPC)   r_epc   <= bus.CP0WData;
        end
    end

    // Redirect target latched with the event, presented during REDIRECT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_target <= 32'h0;
        else if (w_take_exc)  r_target <= EXC_VECTOR;
        else if (w_take_eret) r_target <= r_epc;
    end

    // MFC0 read mux: pre-edge register values, unimplemented numbers read 0.
    always_comb begin
        w_rdata = 32'h0;
        if (bus.InstValid && bus.CP0RE) begin
            case (bus.CP0RAddr)
                c_REG_COUNT:   w_rdata = r_count;
                c_REG_COMPARE: w_rdata = r_compare;
                c_REG_STATUS:  w_rdata = w_status;
                c_REG_CAUSE:   w_rdata = w_cause;
                c_REG_EPC:     w_rdata = r_epc;
                default:       w_rdata = 32'h0;
            endcase
        end
    end

    assign bus.CP0RData = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exception_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_exception_unit
// Description : Scoreboard bench for cp0_exception_unit: directed stimulus
//               pushes expected redirects and MFC0 read values; a monitor
//               compares them whenever the DUT presents PcLoad or read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_exception_unit;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    string       redir_name_q[$];
    logic [31:0] redir_val_q[$];
    string       read_name_q[$];
    logic [31:0] read_val_q[$];
    logic        prev_flush;

    cp0_exception_unit_if #(.NUM_HW_INT(5)) bus ();

    cp0_exception_unit #(
        .NUM_HW_INT (5),
        .EXC_VECTOR (32'h0000_8000),
        .COUNT_DIV  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.InstValid   = 1'b0;
        bus.InstPC      = 32'h0;
        bus.InDelaySlot = 1'b0;
        bus.ExcSyscall  = 1'b0;
        bus.ExcEret     = 1'b0;
        bus.CP0RE       = 1'b0;
        bus.CP0RAddr    = 5'd0;
        bus.CP0WE       = 1'b0;
        bus.CP0WAddr    = 5'd0;
        bus.CP0WData    = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        idle();
        bus.InstValid = 1'b1;
        bus.CP0WE     = 1'b1;
        bus.CP0WAddr  = addr;
        bus.CP0WData  = data;
        tick();
        idle();
    endtask

    task automatic mfc0(input logic [4:0] addr, input logic [31:0] exp, input string name);
        read_name_q.push_back(name);
        read_val_q.push_back(exp);
        idle();
        bus.InstValid = 1'b1;
        bus.CP0RE     = 1'b1;
        bus.CP0RAddr  = addr;
        tick();
        idle();
    endtask

    // Monitor: compares redirects and read data against the scoreboard queues.
    initial begin
        string       nm;
        logic [31:0] v;
        prev_flush = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.PcLoad) begin
                    if (redir_val_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_redirect: got PcTarget 0x%08h, expected no redirect", bus.PcTarget);
                    end else begin
                        nm = redir_name_q.pop_front();
                        v  = redir_val_q.pop_front();
                        check({nm, "_target"}, bus.PcTarget, v);
                        check({nm, "_flush_before"}, {31'h0, prev_flush}, 32'h1);
                    end
                end
                if (bus.InstValid && bus.CP0RE) begin
                    if (read_val_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_read: got 0x%08h, expected no read", bus.CP0RData);
                    end else begin
                        nm = read_name_q.pop_front();
                        v  = read_val_q.pop_front();
                        check(nm, bus.CP0RData, v);
                    end
                end
            end
            prev_flush = bus.Flush;
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    // Directed stimulus.
    initial begin
        rst_n     = 1'b0;
        bus.HwInt = 5'b0;
        idle();
        repeat (3) tick();
        check("rst_flush",    {31'h0, bus.Flush},    32'h0);
        check("rst_pcload",   {31'h0, bus.PcLoad},   32'h0);
        check("rst_pctarget", bus.PcTarget,          32'h0);
        check("rst_timerirq", {31'h0, bus.TimerIrq}, 32'h0);
        rst_n = 1'b1;
        tick();
        mfc0(5'd12, 32'h0, "rst_status");
        mfc0(5'd14, 32'h0, "rst_epc");
        mfc0(5'd5,  32'h0, "unimpl_reg");

        // Syscall from 0x100 with IE=1.
        mtc0(5'd12, 32'h0000_0001);
        redir_name_q.push_back("sys");
        redir_val_q.push_back(32'h0000_8000);
        bus.InstValid  = 1'b1;
        bus.InstPC     = 32'h0000_0100;
        bus.ExcSyscall = 1'b1;
        #1;
        check("sys_flush", {31'h0, bus.Flush}, 32'h1);
        tick();
        idle();
        tick();
        mfc0(5'd14, 32'h0000_0100, "sys_epc");
        mfc0(5'd13, 32'h0000_0020, "sys_cause");
        mfc0(5'd12, 32'h0000_0003, "sys_status");

        // ERET back to 0x1234.
        mtc0(5'd14, 32'h0000_1234);
        redir_name_q.push_back("eret");
        redir_val_q.push_back(32'h0000_1234);
        bus.InstValid = 1'b1;
        bus.ExcEret   = 1'b1;
        tick();
        idle();
        tick();
        mfc0(5'd12, 32'h0000_0001, "eret_status");

        // Delay-slot interrupt via HwInt[0]: taken in the third cycle.
        mtc0(5'd12, 32'h0000_0401);
        redir_name_q.push_back("int_ds");
        redir_val_q.push_back(32'h0000_8000);
        bus.HwInt       = 5'b00001;
        bus.InstValid   = 1'b1;
        bus.InstPC      = 32'h0000_0204;
        bus.InDelaySlot = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("int_ds_flush_c%0d", c), {31'h0, bus.Flush}, (c == 3) ? 32'h1 : 32'h0);
            tick();
        end
        idle();
        tick();
        mfc0(5'd14, 32'h0000_0200, "int_ds_epc");
        mfc0(5'd13, 32'h8000_0400, "int_ds_cause");
        mfc0(5'd12, 32'h0000_0403, "int_ds_status");

        // EXL=1 masks the still-pending interrupt.
        bus.InstValid = 1'b1;
        bus.InstPC    = 32'h0000_0300;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("exl_mask_flush", {31'h0, bus.Flush}, 32'h0);
            tick();
        end
        idle();

        // Interrupt beats syscall; same-cycle Status write is dropped.
        mtc0(5'd12, 32'h0000_0401);
        redir_name_q.push_back("prio");
        redir_val_q.push_back(32'h0000_8000);
        bus.InstValid  = 1'b1;
        bus.InstPC     = 32'h0000_0500;
        bus.ExcSyscall = 1'b1;
        bus.CP0WE      = 1'b1;
        bus.CP0WAddr   = 5'd12;
        bus.CP0WData   = 32'h0;
        tick();
        idle();
        tick();
        mfc0(5'd13, 32'h0000_0400, "prio_cause");
        mfc0(5'd12, 32'h0000_0403, "prio_status");
        mfc0(5'd14, 32'h0000_0500, "prio_epc");
        bus.HwInt = 5'b0;
        mtc0(5'd12, 32'h0);

        // Timer: Compare=5, Count=0, COUNT_DIV=2 -> TI on the 10th edge.
        mtc0(5'd11, 32'd5);
        mtc0(5'd9,  32'd0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("timer_ti_k%0d", k), {31'h0, bus.TimerIrq}, (k >= 10) ? 32'h1 : 32'h0);
            tick();
        end
        mfc0(5'd13, 32'h4000_8000, "timer_cause_ti");
        mtc0(5'd11, 32'h0000_0100);
        #1;
        check("timer_clear_ti", {31'h0, bus.TimerIrq}, 32'h0);
        mfc0(5'd13, 32'h0, "timer_clear_cause");

        // Compare write on the very edge where Count reaches Compare.
        mtc0(5'd11, 32'd3);
        mtc0(5'd9,  32'd0);
        repeat (5) tick();
        mtc0(5'd11, 32'h0000_0200);
        #1;
        check("same_edge_ti", {31'h0, bus.TimerIrq}, 32'h0);
        mfc0(5'd9,  32'd3, "same_edge_count");
        mfc0(5'd13, 32'h0, "same_edge_cause");

        // Reset asserted while in REDIRECT.
        mtc0(5'd12, 32'h0000_0001);
        bus.InstValid  = 1'b1;
        bus.InstPC     = 32'h0000_0600;
        bus.ExcSyscall = 1'b1;
        tick();
        idle();
        check("rst_redir_pcload_before", {31'h0, bus.PcLoad}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_redir_pcload",   {31'h0, bus.PcLoad},   32'h0);
        check("rst_redir_flush",    {31'h0, bus.Flush},    32'h0);
        check("rst_redir_pctarget", bus.PcTarget,          32'h0);
        check("rst_redir_ti",       {31'h0, bus.TimerIrq}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        mfc0(5'd12, 32'h0, "rst_redir_status");
        mfc0(5'd13, 32'h0, "rst_redir_cause");
        mfc0(5'd14, 32'h0, "rst_redir_epc");

        repeat (2) tick();
        check("redir_q_empty", redir_val_q.size(), 32'h0);
        check("read_q_empty",  read_val_q.size(),  32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
